// File: rtl/nibble_serial_alu.sv
// Nibble-serial integer ALU: one 4-bit slice per clock, LSB first, with a carry/borrow chain.
// Handshakes on both sides. Results and flags stay latched until the consumer accepts them.
module nibble_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [2:0]       alu_op,
    input  logic             in_C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_Z,
    output logic             out_N,
    output logic             out_H,
    output logic             out_C
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             carry, h_int;
    logic [IW-1:0]    idx;

    logic [WIDTH-1:0] a_sh, b_sh, res_next;
    logic [5:0]       shamt;
    logic [3:0]       a_n, b_n, nib;
    logic [4:0]       sum, diff;
    logic             cout, last, arith;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        shamt = 6'({idx, 2'b00});
        a_sh  = a_q >> shamt;
        b_sh  = b_q >> shamt;
        a_n   = a_sh[3:0];
        b_n   = b_sh[3:0];
        sum   = {1'b0, a_n} + {1'b0, b_n} + {4'b0, carry};
        // Bit 4 of the 5-bit difference is the borrow out of this nibble.
        diff  = {1'b0, a_n} - {1'b0, b_n} - {4'b0, carry};
        nib   = 4'h0;
        cout  = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC:         begin nib = sum[3:0];  cout = sum[4];  end
            OP_SUB, OP_SBC, OP_CP:  begin nib = diff[3:0]; cout = diff[4]; end
            OP_AND:                 nib = a_n & b_n;
            OP_XOR:                 nib = a_n ^ b_n;
            default:                nib = a_n | b_n;
        endcase
        res_next = (res_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(nib) << shamt);
        last     = (idx == IW'(NIBBLES - 1));
        arith    = !op_q[2] || (op_q == OP_CP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= OP_ADD;
            carry <= 1'b0;
            h_int <= 1'b0;
            idx   <= '0;
            out   <= '0;
            out_Z <= 1'b0;
            out_N <= 1'b0;
            out_H <= 1'b0;
            out_C <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= in_A;
                    b_q   <= in_B;
                    op_q  <= alu_op;
                    carry <= in_C && (alu_op == OP_ADC || alu_op == OP_SBC);
                    res_q <= '0;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    res_q <= res_next;
                    carry <= cout;
                    idx   <= idx + IW'(1);
                    if (idx == '0) h_int <= cout;
                    if (last) begin
                        // cp reports flags of A-B but passes A through unchanged.
                        out   <= (op_q == OP_CP) ? a_q : res_next;
                        out_Z <= (res_next == '0);
                        out_N <= (op_q == OP_SUB || op_q == OP_SBC || op_q == OP_CP);
                        out_H <= arith ? ((idx == '0) ? cout : h_int) : (op_q == OP_AND);
                        out_C <= arith ? cout : 1'b0;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu: an 8-bit and a 16-bit instance share clock and reset.
module tb_nibble_serial_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v8 = 0, c8 = 0, or8 = 0, ir8, ov8, z8, n8, h8, cf8;
    logic [7:0]  a8 = 0, b8 = 0, o8;
    logic [2:0]  op8 = 0;
    logic        v16 = 0, c16 = 0, or16 = 0, ir16, ov16, z16, n16, h16, cf16;
    logic [15:0] a16 = 0, b16 = 0, o16;
    logic [2:0]  op16 = 0;

    nibble_serial_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_A(a8), .in_B(b8),
        .alu_op(op8), .in_C(c8), .out_valid(ov8), .out_ready(or8), .out(o8),
        .out_Z(z8), .out_N(n8), .out_H(h8), .out_C(cf8));

    nibble_serial_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_A(a16), .in_B(b16),
        .alu_op(op16), .in_C(c16), .out_valid(ov16), .out_ready(or16), .out(o16),
        .out_Z(z16), .out_N(n16), .out_H(h16), .out_C(cf16));

    int lat, acc_cyc;

    // Drive one 8-bit request, then count edges until out_valid (bounded).
    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; c8 = c; v8 = 1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        v8 = 0;
        lat = 0;
        while (!ov8 && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; c16 = c; v16 = 1;
        @(posedge clk); #1;
        v16 = 0;
        lat = 0;
        while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic pop8();
        @(negedge clk); or8 = 1;
        @(posedge clk); #1; or8 = 0;
    endtask

    task automatic pop16();
        @(negedge clk); or16 = 1;
        @(posedge clk); #1; or16 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        vectors++;
        if ({ir8, ov8, o8, z8, n8, h8, cf8} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            errors++; $display("FAIL reset8 got %b exp %b", {ir8, ov8, o8, z8, n8, h8, cf8},
                               {1'b1, 1'b0, 8'h00, 4'b0000});
        end
        vectors++;
        if ({ir16, ov16, o16, z16, n16, h16, cf16} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
            errors++; $display("FAIL reset16 got %b", {ir16, ov16, o16, z16, n16, h16, cf16});
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_add();
        run8(3'd0, 8'h3A, 8'hC6, 1'b0);
        vectors++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h00, 4'b1011}) begin
            errors++; $display("FAIL add got %h/%b exp 00/1011", o8, {z8, n8, h8, cf8});
        end
        pop8();
    endtask

    task automatic test_sub();
        run8(3'd3, 8'h10, 8'h01, 1'b1);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h0E, 4'b0110}) begin
            errors++; $display("FAIL sbc got %h/%b exp 0e/0110", o8, {z8, n8, h8, cf8});
        end
        pop8();
        run8(3'd2, 8'h10, 8'h01, 1'b1);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h0F, 4'b0110}) begin
            errors++; $display("FAIL sub got %h/%b exp 0f/0110", o8, {z8, n8, h8, cf8});
        end
        pop8();
    endtask

    task automatic test_cp();
        run8(3'd7, 8'h42, 8'h42, 1'b1);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h42, 4'b1100}) begin
            errors++; $display("FAIL cp_eq got %h/%b exp 42/1100", o8, {z8, n8, h8, cf8});
        end
        pop8();
        run8(3'd7, 8'h10, 8'h20, 1'b0);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h10, 4'b0101}) begin
            errors++; $display("FAIL cp_lt got %h/%b exp 10/0101", o8, {z8, n8, h8, cf8});
        end
        vectors++;
        if (lat !== 2) begin errors++; $display("FAIL cp_latency got %0d exp 2", lat); end
        pop8();
    endtask

    task automatic test_logic();
        run8(3'd4, 8'hF0, 8'h0F, 1'b1);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h00, 4'b1010}) begin
            errors++; $display("FAIL and got %h/%b exp 00/1010", o8, {z8, n8, h8, cf8});
        end
        pop8();
        run8(3'd6, 8'hF0, 8'h0F, 1'b1);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'hFF, 4'b0000}) begin
            errors++; $display("FAIL or got %h/%b exp ff/0000", o8, {z8, n8, h8, cf8});
        end
        pop8();
        run8(3'd5, 8'h5A, 8'h0F, 1'b0);
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h55, 4'b0000}) begin
            errors++; $display("FAIL xor got %h/%b exp 55/0000", o8, {z8, n8, h8, cf8});
        end
        pop8();
    endtask

    task automatic test_backpressure();
        run8(3'd0, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = ~a8; b8 = 8'hFF; op8 = 3'd4; v8 = (i % 2 == 0);
            @(posedge clk); #1;
            vectors++;
            if ({ir8, ov8, o8, z8, n8, h8, cf8} !== {1'b0, 1'b1, 8'h46, 4'b0000}) begin
                errors++; $display("FAIL hold%0d got %b", i, {ir8, ov8, o8, z8, n8, h8, cf8});
            end
        end
        @(negedge clk); v8 = 0; or8 = 1;
        @(posedge clk); #1; or8 = 0;
        vectors++;
        if ({ir8, ov8} !== 2'b10) begin
            errors++; $display("FAIL release got ir/ov %b exp 10", {ir8, ov8});
        end
    endtask

    task automatic test_back_to_back();
        int first;
        run8(3'd1, 8'hFF, 8'h00, 1'b1);
        first = acc_cyc;
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'h00, 4'b1011}) begin
            errors++; $display("FAIL adc8 got %h/%b exp 00/1011", o8, {z8, n8, h8, cf8});
        end
        pop8();
        run8(3'd2, 8'h00, 8'h01, 1'b0);
        vectors++;
        if (acc_cyc - first !== 4) begin
            errors++; $display("FAIL interval got %0d exp 4", acc_cyc - first);
        end
        vectors++;
        if ({o8, z8, n8, h8, cf8} !== {8'hFF, 4'b0111}) begin
            errors++; $display("FAIL b2b_sub got %h/%b exp ff/0111", o8, {z8, n8, h8, cf8});
        end
        pop8();
    endtask

    task automatic test_wide_reset();
        run16(3'd1, 16'hFFFF, 16'h0000, 1'b1);
        vectors++;
        if (lat !== 4) begin errors++; $display("FAIL adc16_latency got %0d exp 4", lat); end
        vectors++;
        if ({o16, z16, n16, h16, cf16} !== {16'h0000, 4'b1011}) begin
            errors++; $display("FAIL adc16 got %h/%b exp 0000/1011", o16, {z16, n16, h16, cf16});
        end
        pop16();
        @(negedge clk);
        op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1; v16 = 1;
        @(posedge clk); #1; v16 = 0;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        vectors++;
        if ({ir16, ov16, o16, z16, n16, h16, cf16} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
            errors++; $display("FAIL midrun_reset got %b", {ir16, ov16, o16, z16, n16, h16, cf16});
        end
        @(negedge clk); rst_n = 1;
        run16(3'd0, 16'h0FFF, 16'h0001, 1'b1);
        vectors++;
        if ({lat, o16, z16, n16, h16, cf16} !== {32'd4, 16'h1000, 4'b0010}) begin
            errors++; $display("FAIL post_reset lat %0d got %h/%b exp 4 1000/0010",
                               lat, o16, {z16, n16, h16, cf16});
        end
        pop16();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_cp();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_wide_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
